// File: rtl/dmi_sync_pkg.sv
// Shared limits, channel indices and the fixed-priority picker used by the
// DMI request synchroniser/arbiter.
package dmi_sync_pkg;

   localparam int MAX_CH   = 16;
   localparam int MIN_SYNC = 2;
   localparam int MAX_SYNC = 4;
   localparam int IDX_W    = $clog2(MAX_CH);

   localparam int CH_RD = 0;
   localparam int CH_WR = 1;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [MAX_CH-1:0] onehot;
   } pick_t;

   // Lowest set bit wins; an all-zero vector yields idx 0 and onehot 0.
   function automatic pick_t lowest_set(input logic [MAX_CH-1:0] v);
      pick_t r;
      r = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (v[i]) begin
            r.idx       = i[IDX_W-1:0];
            r.onehot    = '0;
            r.onehot[i] = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dmi_sync_chain.sv
// One-bit multi-flop synchroniser; isolated so the CDC flops can carry the
// synchroniser attribute or be replaced by a library cell.
module dmi_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* async_reg = "true" *) logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dmi_req_sync_arb.sv
// Synchronises TCK-domain request levels, latches edges as sticky pending
// requests and drains them through a fixed-priority valid/ready port.
module dmi_req_sync_arb
   import dmi_sync_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_BOTH   = 1'b0,
   localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req_in,
   output logic              req_valid,
   output logic [CHW-1:0]    req_ch,
   output logic [NUM_CH-1:0] req_onehot,
   input  logic              req_ready,
   output logic [NUM_CH-1:0] ack_toggle,
   output logic [NUM_CH-1:0] overrun,
   input  logic [NUM_CH-1:0] clr_overrun
);

   if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
      $error("dmi_req_sync_arb: NUM_CH out of range");
   end
   if (SYNC_STAGES < MIN_SYNC || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
      $error("dmi_req_sync_arb: SYNC_STAGES out of range");
   end

   logic [NUM_CH-1:0] sync_s;
   logic [NUM_CH-1:0] hist_q, hist_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [NUM_CH-1:0] overrun_q, overrun_d;
   logic [NUM_CH-1:0] edge_det, grant, take;
   logic [MAX_CH-1:0] pend_ext;
   pick_t             pick;
   logic              accept;
   logic              unused_pick;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      dmi_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (req_in[i]),
         .q     (sync_s[i])
      );
   end

   always_comb begin
      pend_ext                = '0;
      pend_ext[NUM_CH-1:0]    = pending_q;
      pick                    = lowest_set(pend_ext);
      grant                   = pick.onehot[NUM_CH-1:0];
      accept                  = (|pending_q) & req_ready;
      take                    = grant & {NUM_CH{accept}};
      edge_det                = EDGE_BOTH ? (sync_s ^ hist_q) : (sync_s & ~hist_q);
   end

   // A new edge on the channel being accepted re-arms it rather than overrunning.
   always_comb begin
      hist_d    = sync_s;
      pending_d = (pending_q & ~take) | edge_det;
      ack_d     = ack_q ^ take;
      overrun_d = (edge_det & pending_q & ~take) | (overrun_q & ~clr_overrun);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q    <= '0;
         pending_q <= '0;
         ack_q     <= '0;
         overrun_q <= '0;
      end else begin
         hist_q    <= hist_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         overrun_q <= overrun_d;
      end
   end

   assign unused_pick = ^pick;
   assign req_valid   = |pending_q;
   assign req_ch      = pick.idx[CHW-1:0];
   assign req_onehot  = grant;
   assign ack_toggle  = ack_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_dmi_req_sync_arb.sv
// Directed checks of the request synchroniser/arbiter: default instance plus
// a 4-channel, 3-stage, both-edge instance.
module tb_dmi_req_sync_arb;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req_in = '0, clr_overrun = '0, req_onehot, ack_toggle, overrun;
   logic       req_ready = 1'b0, req_valid;
   logic [0:0] req_ch;
   logic [3:0] req_in4 = '0, clr4 = '0, onehot4, ack4, ovr4;
   logic       ready4 = 1'b0, valid4;
   logic [1:0] ch4;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   dmi_req_sync_arb u_dut (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .req_valid(req_valid),
      .req_ch(req_ch), .req_onehot(req_onehot), .req_ready(req_ready),
      .ack_toggle(ack_toggle), .overrun(overrun), .clr_overrun(clr_overrun)
   );

   dmi_req_sync_arb #(.NUM_CH(4), .SYNC_STAGES(3), .EDGE_BOTH(1'b1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_in(req_in4), .req_valid(valid4),
      .req_ch(ch4), .req_onehot(onehot4), .req_ready(ready4),
      .ack_toggle(ack4), .overrun(ovr4), .clr_overrun(clr4)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_in = '0; req_in4 = '0; req_ready = 1'b0; ready4 = 1'b0;
      clr_overrun = '0; clr4 = '0;
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      // reset state
      do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid",   {31'd0, req_valid}, 0);
      chk("rst_onehot",  {30'd0, req_onehot}, 0);
      chk("rst_ch",      {31'd0, req_ch}, 0);
      chk("rst_ack",     {30'd0, ack_toggle}, 0);
      chk("rst_ovr",     {30'd0, overrun}, 0);
      chk("rst_valid4",  {31'd0, valid4}, 0);
      rst_n = 1'b1;

      // T1: rd pulse held 5 cycles, ready=1
      step(1);
      req_ready = 1'b1; req_in = 2'b01;
      step(2); chk("t1_valid_early", {31'd0, req_valid}, 0);
      step(1); chk("t1_valid",  {31'd0, req_valid}, 1);
      chk("t1_ch",     {31'd0, req_ch}, 0);
      chk("t1_onehot", {30'd0, req_onehot}, 32'h1);
      step(1); chk("t1_valid_off", {31'd0, req_valid}, 0);
      chk("t1_ack",    {30'd0, ack_toggle}, 32'h1);
      req_in = 2'b00;
      step(5); chk("t1_no_rerequest", {31'd0, req_valid}, 0);
      chk("t1_ovr",    {30'd0, overrun}, 0);

      // T2: rd and wr together
      do_reset(); step(1);
      req_ready = 1'b1; req_in = 2'b11;
      step(3); chk("t2_ch_a", {31'd0, req_ch}, 0);
      chk("t2_onehot_a", {30'd0, req_onehot}, 32'h1);
      step(1); chk("t2_ch_b", {31'd0, req_ch}, 1);
      chk("t2_onehot_b", {30'd0, req_onehot}, 32'h2);
      chk("t2_valid_b",  {31'd0, req_valid}, 1);
      step(1); chk("t2_valid_off", {31'd0, req_valid}, 0);
      chk("t2_ack",      {30'd0, ack_toggle}, 32'h3);

      // T3: merge while not ready -> overrun, then clear
      do_reset(); step(1);
      req_in = 2'b10;
      step(3); chk("t3_valid", {31'd0, req_valid}, 1);
      chk("t3_ch", {31'd0, req_ch}, 1);
      step(3); req_in = 2'b00;
      step(6); req_in = 2'b10;
      step(2); chk("t3_ovr_pre", {30'd0, overrun}, 0);
      step(1); chk("t3_ovr_set", {30'd0, overrun}, 32'h2);
      chk("t3_valid_held", {31'd0, req_valid}, 1);
      req_ready = 1'b1;
      step(1); chk("t3_valid_off", {31'd0, req_valid}, 0);
      chk("t3_ack", {30'd0, ack_toggle}, 32'h2);
      chk("t3_ovr_sticky", {30'd0, overrun}, 32'h2);
      clr_overrun = 2'b10;
      step(1); chk("t3_ovr_clr", {30'd0, overrun}, 0);
      clr_overrun = 2'b00;

      // T4: both-edge instance, ch3 toggled twice
      do_reset(); step(1);
      ready4 = 1'b1; req_in4 = 4'b1000;
      step(3); chk("t4_valid_early", {31'd0, valid4}, 0);
      step(1); chk("t4_valid_a", {31'd0, valid4}, 1);
      chk("t4_ch_a", {30'd0, ch4}, 3);
      chk("t4_onehot_a", {28'd0, onehot4}, 32'h8);
      step(1); chk("t4_ack_a", {28'd0, ack4}, 32'h8);
      chk("t4_valid_off_a", {31'd0, valid4}, 0);
      step(3); req_in4 = 4'b0000;
      step(4); chk("t4_valid_b", {31'd0, valid4}, 1);
      chk("t4_ch_b", {30'd0, ch4}, 3);
      step(1); chk("t4_ack_b", {28'd0, ack4}, 0);
      chk("t4_ovr", {28'd0, ovr4}, 0);

      // T5: edge coincident with accept of pending ch0
      do_reset(); step(1);
      req_in = 2'b01;
      step(3); chk("t5_valid", {31'd0, req_valid}, 1);
      req_in = 2'b00;
      step(3); req_in = 2'b01;
      step(2); req_ready = 1'b1;
      step(1); chk("t5_still_valid", {31'd0, req_valid}, 1);
      chk("t5_ack_1", {30'd0, ack_toggle}, 32'h1);
      step(1); chk("t5_valid_off", {31'd0, req_valid}, 0);
      chk("t5_ack_2", {30'd0, ack_toggle}, 0);
      chk("t5_ovr", {30'd0, overrun}, 0);

      // T6: reset while pending with inputs held high
      do_reset(); step(1);
      req_in = 2'b11;
      step(4); chk("t6_pending", {31'd0, req_valid}, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid",  {31'd0, req_valid}, 0);
      chk("t6_rst_onehot", {30'd0, req_onehot}, 0);
      step(1);
      rst_n = 1'b1; req_ready = 1'b1;
      step(2); chk("t6_valid_early", {31'd0, req_valid}, 0);
      step(1); chk("t6_ch_a", {31'd0, req_ch}, 0);
      chk("t6_valid_a", {31'd0, req_valid}, 1);
      step(1); chk("t6_ch_b", {31'd0, req_ch}, 1);
      step(1); chk("t6_valid_off", {31'd0, req_valid}, 0);
      step(4); chk("t6_once_only", {31'd0, req_valid}, 0);
      chk("t6_ack", {30'd0, ack_toggle}, 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
